decode_stage: RTL and testbench
===============================

# decode_stage

IF/ID pipeline register and instruction decoder for the 8-bit processor, directly downstream of instruction fetch. Captures each fetched 16-bit instruction with its 6-bit PC, decodes it into register indices, a sign-extended immediate and control strobes, and registers the result for the execute stage. Also detects load-use hazards, tells fetch to hold, and inserts a bubble. Keeps a saturating count of illegal encodings for debug.

## Interface
- No parameters; widths are fixed by the ISA (16-bit instruction, 3-bit register index, 8-bit datapath, 6-bit PC).
- Clock and reset: single clock `clk`; reset `rst` is asynchronous, active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous active-high reset.
- `if_instr` in 16: instruction from fetch.
- `if_pc` in 6: PC of `if_instr`.
- `if_valid` in 1: `if_instr` is a real instruction.
- `stall` in 1: downstream hold; freeze all ID registers.
- `flush` in 1: discard; load a bubble.
- `hold_fetch` out 1: combinational; fetch must not advance the PC this cycle.
- `id_valid` out 1: ID register holds a real instruction.
- `id_pc` out 6: captured PC.
- `id_dst`, `id_src1`, `id_src2` out 3 each: destination and source register indices.
- `id_imm` out 8: sign-extended immediate, or jump offset.
- `id_alu_op` out 3: ALU function.
- `id_alu_src_imm` out 1: ALU operand B is `id_imm`.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_jump`, `id_illegal` out 1 each: control strobes.
- `illegal_count` out 8: saturating count of illegal instructions accepted.

## Operation
- Opcode field is `[15:12]`.
- **R-type, 0000:** `dst=[11:9]`, `src1=[8:6]`, `src2=[5:3]`, `alu_op=[2:0]`. Funct codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 BIC, 110 RSB. Asserts `reg_write`. Funct 111 is illegal.
- **I-type fields:** `rt=[11:9]`, `rs=[8:6]`, `imm = sign-extend([5:0])` to 8 bits. `src1 = rs`.
  - **ADDI, 0100:** `dst=rt`, `alu_op=ADD`, `alu_src_imm`, `reg_write`.
  - **LW, 1011:** `dst=rt`, `alu_op=ADD`, `alu_src_imm`, `reg_write`, `mem_read`.
  - **SW, 1111:** `src2=rt`, `alu_op=ADD`, `alu_src_imm`, `mem_write`.
  - **BEQ, 1000:** `src2=rt`, `alu_op=SUB`, `branch`.
- **J, 0010:** `imm = [7:0]` raw, `jump`; all other strobes 0.
- **Illegal:** any other opcode, or R-type funct 111. Sets `illegal` and clears every other strobe; `id_valid` is still 1.
- **Unused fields:** index fields an instruction does not use are driven 0.
- **Bubble:** `id_valid=0`, all strobes 0, all fields 0.
- **Load-use hazard:** asserted when all of the following hold: `id_valid`, `id_mem_read`, `if_valid`, and the incoming instruction actually reads `src1` or `src2` with a value equal to `id_dst`. Register 0 is not special. The hazard is suppressed while `stall` or `flush` is asserted.
- **hold_fetch:** equals `hazard | stall`.
- **Update priority at each rising edge:** `rst` > `flush` (bubble) > `stall` (hold) > `hazard` (bubble; fetch keeps the instruction) > load decoded `if_instr`. `if_valid=0` loads a bubble.
- **illegal_count:** increments when an illegal instruction is loaded. Saturates at 255.

## Timing
- Reset state: all `id_*` are 0, `illegal_count=0`, and `hold_fetch` depends only on inputs.
- Latency is one cycle from `if_instr` to `id_*`.
- Load-use costs exactly one bubble: the dependent instruction enters the cycle after the bubble, because by then `id_mem_read` is 0.
- `stall` and `flush` asserted together: flush wins.
- `rst` asserted mid-stall or mid-hazard clears everything immediately, asynchronously.

## Structure
- **Package `cpu_pkg`:** opcode constants (`OP_RTYPE`, `OP_ADDI`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`), ALU funct enum `alu_op_e`, and a packed struct `ctrl_t` holding the strobes.
- **Sub-module `instr_decoder`:** purely combinational, 16-bit instruction → fields, `ctrl_t`, `illegal`. It is reused for the hazard source-usage check.
- **Top level:** the pipeline register, hazard logic and counter.

## Test plan
- **Reset:** assert `rst` mid-stream → all outputs 0 asynchronously; `illegal_count=0`.
- **Decode sweep:**
  - 16'b0000_010_001_000_001 → SUB, `dst=2`, `src1=1`, `src2=0`, `reg_write=1`.
  - 16'b0100_111_111_111000 → ADDI, `dst=7`, `imm=8'hF8`, `alu_src_imm=1`.
  - 16'b0010_0011_00000011 → `jump=1`, `imm=8'h03`.
- **Load-use:** LW 16'b1011_111_011_001001, then ADD 16'b0000_010_111_000_000 → `hold_fetch=1` for one cycle, one bubble, then ADD with `src1=7`.
- **No false hazard:** LW to r7, then BEQ on r1/r2 → no hold. LW to r7, then SW with `rt=7` → hold asserted.
- **Stall/flush:** `stall` for 3 cycles → `id_*` frozen. `stall` and `flush` in the same cycle → bubble.
- **Illegal:** feed 300 illegal words (e.g. opcode 0001, or R-type funct 111) → strobes 0, `id_illegal=1`, `illegal_count` saturates at 255.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 8-bit processor front end.
// Covers opcodes, ALU function codes and the decoded control and ID-register layouts.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_J     = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_LW    = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b1111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_EOR = 3'b100,
        ALU_BIC = 3'b101,
        ALU_RSB = 3'b110
    } alu_op_e;

    typedef struct packed {
        logic alu_src_imm;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ctrl_t;

    // Decoder result; rd_src* say whether the instruction really reads that index.
    typedef struct packed {
        logic [2:0] dst;
        logic [2:0] src1;
        logic [2:0] src2;
        logic [7:0] imm;
        alu_op_e    alu_op;
        ctrl_t      ctrl;
        logic       illegal;
        logic       rd_src1;
        logic       rd_src2;
    } decoded_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] pc;
        logic [2:0] dst;
        logic [2:0] src1;
        logic [2:0] src2;
        logic [7:0] imm;
        alu_op_e    alu_op;
        ctrl_t      ctrl;
        logic       illegal;
    } id_reg_t;

    function automatic logic [7:0] sext6(input logic [5:0] v);
        return {{2{v[5]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational 16-bit instruction decoder: fields, control strobes, illegal flag.
// Also reports which source indices are genuinely read, for load-use detection.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] instr_i,
    output decoded_t    dec_o
);

    logic [3:0] opcode;
    assign opcode = instr_i[15:12];

    always_comb begin
        dec_o = '0;
        case (opcode)
            OP_RTYPE: begin
                if (instr_i[2:0] == 3'b111) begin
                    dec_o.illegal = 1'b1;
                end else begin
                    dec_o.dst            = instr_i[11:9];
                    dec_o.src1           = instr_i[8:6];
                    dec_o.src2           = instr_i[5:3];
                    dec_o.alu_op         = alu_op_e'(instr_i[2:0]);
                    dec_o.ctrl.reg_write = 1'b1;
                    dec_o.rd_src1        = 1'b1;
                    dec_o.rd_src2        = 1'b1;
                end
            end
            OP_ADDI, OP_LW: begin
                dec_o.dst              = instr_i[11:9];
                dec_o.src1             = instr_i[8:6];
                dec_o.imm              = sext6(instr_i[5:0]);
                dec_o.alu_op           = ALU_ADD;
                dec_o.ctrl.alu_src_imm = 1'b1;
                dec_o.ctrl.reg_write   = 1'b1;
                dec_o.ctrl.mem_read    = (opcode == OP_LW);
                dec_o.rd_src1          = 1'b1;
            end
            OP_SW: begin
                dec_o.src1             = instr_i[8:6];
                dec_o.src2             = instr_i[11:9];
                dec_o.imm              = sext6(instr_i[5:0]);
                dec_o.alu_op           = ALU_ADD;
                dec_o.ctrl.alu_src_imm = 1'b1;
                dec_o.ctrl.mem_write   = 1'b1;
                dec_o.rd_src1          = 1'b1;
                dec_o.rd_src2          = 1'b1;
            end
            OP_BEQ: begin
                dec_o.src1        = instr_i[8:6];
                dec_o.src2        = instr_i[11:9];
                dec_o.imm         = sext6(instr_i[5:0]);
                dec_o.alu_op      = ALU_SUB;
                dec_o.ctrl.branch = 1'b1;
                dec_o.rd_src1     = 1'b1;
                dec_o.rd_src2     = 1'b1;
            end
            OP_J: begin
                dec_o.imm       = instr_i[7:0];
                dec_o.ctrl.jump = 1'b1;
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register with decode, load-use hazard bubble insertion and a
// saturating illegal-instruction counter.
module decode_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_instr,
    input  logic [5:0]  if_pc,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        hold_fetch,
    output logic        id_valid,
    output logic [5:0]  id_pc,
    output logic [2:0]  id_dst,
    output logic [2:0]  id_src1,
    output logic [2:0]  id_src2,
    output logic [7:0]  id_imm,
    output logic [2:0]  id_alu_op,
    output logic        id_alu_src_imm,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_illegal,
    output logic [7:0]  illegal_count
);

    decoded_t dec;
    id_reg_t  id_q, id_d;
    logic [7:0] cnt_q, cnt_d;
    logic src_match;
    logic hazard;

    instr_decoder u_dec (
        .instr_i (if_instr),
        .dec_o   (dec)
    );

    // Only sources the incoming instruction actually reads can create a dependency.
    assign src_match = (dec.rd_src1 && (dec.src1 == id_q.dst)) ||
                       (dec.rd_src2 && (dec.src2 == id_q.dst));
    assign hazard    = id_q.valid && id_q.ctrl.mem_read && if_valid &&
                       !stall && !flush && src_match;
    assign hold_fetch = hazard | stall;

    always_comb begin
        id_d  = id_q;
        cnt_d = cnt_q;
        if (flush) begin
            id_d = '0;
        end else if (stall) begin
            id_d = id_q;
        end else if (hazard) begin
            id_d = '0;
        end else if (if_valid) begin
            id_d.valid   = 1'b1;
            id_d.pc      = if_pc;
            id_d.dst     = dec.dst;
            id_d.src1    = dec.src1;
            id_d.src2    = dec.src2;
            id_d.imm     = dec.imm;
            id_d.alu_op  = dec.alu_op;
            id_d.ctrl    = dec.ctrl;
            id_d.illegal = dec.illegal;
            if (dec.illegal && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            id_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q  <= '0;
            cnt_q <= '0;
        end else begin
            id_q  <= id_d;
            cnt_q <= cnt_d;
        end
    end

    assign id_valid       = id_q.valid;
    assign id_pc          = id_q.pc;
    assign id_dst         = id_q.dst;
    assign id_src1        = id_q.src1;
    assign id_src2        = id_q.src2;
    assign id_imm         = id_q.imm;
    assign id_alu_op      = id_q.alu_op;
    assign id_alu_src_imm = id_q.ctrl.alu_src_imm;
    assign id_reg_write   = id_q.ctrl.reg_write;
    assign id_mem_read    = id_q.ctrl.mem_read;
    assign id_mem_write   = id_q.ctrl.mem_write;
    assign id_branch      = id_q.ctrl.branch;
    assign id_jump        = id_q.ctrl.jump;
    assign id_illegal     = id_q.illegal;
    assign illegal_count  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed ISA cases plus randomized programs against an
// instruction-level reference model; a negedge monitor scores every cycle.
module tb_decode_stage;

    localparam int W = 43;

    logic        clk;
    logic        rst;
    logic [15:0] if_instr;
    logic [5:0]  if_pc;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic        hold_fetch;
    logic        id_valid;
    logic [5:0]  id_pc;
    logic [2:0]  id_dst, id_src1, id_src2;
    logic [7:0]  id_imm;
    logic [2:0]  id_alu_op;
    logic        id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        id_branch, id_jump, id_illegal;
    logic [7:0]  illegal_count;

    decode_stage dut (
        .clk            (clk),
        .rst            (rst),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .stall          (stall),
        .flush          (flush),
        .hold_fetch     (hold_fetch),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_dst         (id_dst),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .id_imm         (id_imm),
        .id_alu_op      (id_alu_op),
        .id_alu_src_imm (id_alu_src_imm),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_branch      (id_branch),
        .id_jump        (id_jump),
        .id_illegal     (id_illegal),
        .illegal_count  (illegal_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       valid;
        logic [5:0] pc;
        logic [2:0] dst;
        logic [2:0] src1;
        logic [2:0] src2;
        logic [7:0] imm;
        logic [2:0] alu;
        logic       asi;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       br;
        logic       jp;
        logic       ill;
    } id_t;

    id_t        m;
    int         m_cnt;
    logic [W-1:0] exp_q[$];
    logic [15:0]  prog[$];
    logic [5:0]   pc_r;
    int n_tests;
    int n_fail;
    logic [3:0] bad_ops [10];

    function automatic id_t ref_decode(input logic [15:0] ins, input logic [5:0] pc);
        id_t r;
        logic [7:0] simm;
        r = '0;
        r.valid = 1'b1;
        r.pc = pc;
        simm = {{2{ins[5]}}, ins[5:0]};
        case (ins[15:12])
            4'h0: begin
                if (ins[2:0] == 3'd7) r.ill = 1'b1;
                else begin
                    r.dst = ins[11:9]; r.src1 = ins[8:6]; r.src2 = ins[5:3];
                    r.alu = ins[2:0]; r.rw = 1'b1;
                end
            end
            4'h4: begin r.dst = ins[11:9]; r.src1 = ins[8:6]; r.imm = simm; r.asi = 1; r.rw = 1; end
            4'hB: begin r.dst = ins[11:9]; r.src1 = ins[8:6]; r.imm = simm; r.asi = 1; r.rw = 1; r.mr = 1; end
            4'hF: begin r.src1 = ins[8:6]; r.src2 = ins[11:9]; r.imm = simm; r.asi = 1; r.mw = 1; end
            4'h8: begin r.src1 = ins[8:6]; r.src2 = ins[11:9]; r.imm = simm; r.alu = 3'd1; r.br = 1; end
            4'h2: begin r.imm = ins[7:0]; r.jp = 1; end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Set of registers the instruction reads, as a one-hot-per-register mask.
    function automatic logic [7:0] ref_reads(input logic [15:0] ins);
        logic [7:0] s;
        s = '0;
        case (ins[15:12])
            4'h0: if (ins[2:0] != 3'd7) begin s[ins[8:6]] = 1'b1; s[ins[5:3]] = 1'b1; end
            4'h4, 4'hB: s[ins[8:6]] = 1'b1;
            4'hF, 4'h8: begin s[ins[8:6]] = 1'b1; s[ins[11:9]] = 1'b1; end
            default: s = '0;
        endcase
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [15:0] ins, input logic [5:0] pc,
                        input logic v, input logic s, input logic f, output logic hold);
        logic haz;
        logic [7:0] rd;
        @(posedge clk);
        #1;
        rst = r; if_instr = ins; if_pc = pc; if_valid = v; stall = s; flush = f;
        if (r) begin
            m = '0;
            m_cnt = 0;
            hold = s;
            exp_q.push_back({hold, m, m_cnt[7:0]});
        end else begin
            rd = ref_reads(ins);
            haz = m.valid && m.mr && v && !s && !f && rd[m.dst];
            hold = haz || s;
            exp_q.push_back({hold, m, m_cnt[7:0]});
            if (f) m = '0;
            else if (s) m = m;
            else if (haz) m = '0;
            else if (v) begin
                m = ref_decode(ins, pc);
                if (m.ill && m_cnt < 255) m_cnt = m_cnt + 1;
            end else m = '0;
        end
    endtask

    // Fetch model: presents prog head each cycle, advances only when not held.
    task automatic run_prog(input int p_stall, input int p_flush, input int p_inval);
        logic hold, s, f, v;
        int cyc;
        cyc = 0;
        while (prog.size() > 0 && cyc < 5000) begin
            s = ($urandom_range(0, 99) < p_stall);
            f = ($urandom_range(0, 99) < p_flush);
            v = ($urandom_range(0, 99) >= p_inval);
            step(1'b0, prog[0], pc_r, v, s, f, hold);
            if (!hold && v) begin
                void'(prog.pop_front());
                pc_r = pc_r + 6'd1;
            end
            cyc++;
        end
        n_tests++;
        if (prog.size() != 0) begin
            n_fail++;
            $display("FAIL run_prog_budget: %0d instructions left, required 0", prog.size());
            prog.delete();
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        logic [2:0] a, b, c;
        a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7)); c = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0, 1: w = {4'hB, a, b, 6'($urandom)};
            2:    w = {4'h0, a, b, c, 3'($urandom_range(0, 6))};
            3:    w = {4'h4, a, b, 6'($urandom)};
            4:    w = {4'hF, a, b, 6'($urandom)};
            5:    w = {4'h8, a, b, 6'($urandom)};
            6:    w = {4'h2, 4'($urandom), 8'($urandom)};
            default: w = 16'($urandom);
        endcase
        return w;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {hold_fetch, id_valid, id_pc, id_dst, id_src1, id_src2, id_imm, id_alu_op,
                     id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write, id_branch,
                     id_jump, id_illegal, illegal_count};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_check @%0t: got %h required %h (hold,valid,pc,dst,s1,s2,imm,alu,asi,rw,mr,mw,br,jp,ill,cnt)",
                             $time, a, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic hold;
        n_tests = 0; n_fail = 0; m = '0; m_cnt = 0; pc_r = '0;
        bad_ops = '{4'h1, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
        rst = 1'b1; if_instr = '0; if_pc = '0; if_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        step(1'b1, 16'h0, 6'd0, 1'b0, 1'b0, 1'b0, hold);
        step(1'b1, 16'h0, 6'd0, 1'b1, 1'b1, 1'b0, hold);
        step(1'b0, 16'h0, 6'd0, 1'b0, 1'b0, 1'b0, hold);

        // decode sweep
        prog.push_back(16'b0000_010_001_000_001);
        prog.push_back(16'b0100_111_111_111000);
        prog.push_back(16'b0010_0011_00000011);
        run_prog(0, 0, 0);

        // load-use, no-false-hazard, SW rt dependency
        prog.push_back(16'b1011_111_011_001001);
        prog.push_back(16'b0000_010_111_000_000);
        prog.push_back(16'b1011_111_011_001001);
        prog.push_back({4'h8, 3'd2, 3'd1, 6'd4});
        prog.push_back(16'b1011_111_011_001001);
        prog.push_back({4'hF, 3'd7, 3'd1, 6'd0});
        run_prog(0, 0, 0);

        // stall for 3 cycles, then stall+flush together
        step(1'b0, 16'b0100_011_001_000101, 6'd20, 1'b1, 1'b0, 1'b0, hold);
        repeat (3) step(1'b0, 16'b0000_001_010_011_010, 6'd21, 1'b1, 1'b1, 1'b0, hold);
        step(1'b0, 16'b0000_001_010_011_010, 6'd21, 1'b1, 1'b1, 1'b1, hold);
        step(1'b0, 16'h0, 6'd0, 1'b0, 1'b0, 1'b0, hold);

        // illegal words until the counter saturates
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                prog.push_back({4'h0, 3'($urandom), 3'($urandom), 3'($urandom), 3'd7});
            else
                prog.push_back({bad_ops[$urandom_range(0, 9)], 12'($urandom)});
        end
        run_prog(0, 0, 0);

        // reset mid-hazard and mid-stall
        step(1'b0, 16'b1011_101_000_000001, 6'd5, 1'b1, 1'b0, 1'b0, hold);
        step(1'b1, 16'b0000_001_101_000_000, 6'd6, 1'b1, 1'b0, 1'b0, hold);
        step(1'b0, 16'b0100_001_010_000011, 6'd7, 1'b1, 1'b0, 1'b0, hold);
        step(1'b1, 16'b0100_001_010_000011, 6'd7, 1'b1, 1'b1, 1'b0, hold);
        step(1'b0, 16'h0, 6'd0, 1'b0, 1'b0, 1'b0, hold);

        // randomized programs with dependencies, stalls, flushes and fetch gaps
        for (int i = 0; i < 400; i++) prog.push_back(rand_instr());
        run_prog(10, 5, 10);
        for (int i = 0; i < 200; i++) prog.push_back(rand_instr());
        run_prog(0, 0, 0);

        step(1'b0, 16'h0, 6'd0, 1'b0, 1'b0, 1'b0, hold);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
